// File: rtl/watch_pkg.sv
// Shared types and BCD helpers for the watch time-setting controller.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } set_state_e;

  localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
  localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] val, input logic [7:0] max);
    if (val == max) return 8'h00;
    if (val[3:0] == 4'd9) return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

  // True when {ht,hu,mt,mu} is a legal 24-hour time.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic [3:0] ht, hu, mt, mu;
    {ht, hu, mt, mu} = t;
    return (mu <= 4'd9) && (mt <= 4'd5) && (hu <= 4'd9) && (ht <= 4'd2) &&
           !((ht == 4'd2) && (hu > 4'd3));
  endfunction

endpackage

// File: rtl/watch_edge_det.sv
// Button level register with rising-edge strobe; RESET_VAL=1 masks a button held through reset.
module watch_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic edge_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= RESET_VAL;
    else       prev_q <= level_i;
  end

  assign edge_o = level_i & ~prev_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: captures the displayed time, steps hours then minutes, reloads the counters.
// Optional idle auto-commit is enabled by defining WATCH_SET_AUTOEXIT_EN.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        mode_i,
  input  logic        inc_i,
  input  logic [15:0] cur_time_i,
  output logic [15:0] ival_o,
  output logic        cnt_rstn_o,
  output logic [1:0]  blank_o,
  output logic [1:0]  state_o
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_bad_timeout
    $error("TIMEOUT_S must be in 1..255");
  end

  set_state_e  state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic        phase_q, phase_d;
  logic        cnt_rstn_q, cnt_rstn_d;
  logic [1:0]  blank_q, blank_d;
  logic        mode_edge, inc_edge, timeout;

  watch_edge_det #(.RESET_VAL(1'b1)) u_mode_edge (
    .clk_i(clk_i), .rst_i(rst_i), .level_i(mode_i), .edge_o(mode_edge)
  );

  watch_edge_det #(.RESET_VAL(1'b1)) u_inc_edge (
    .clk_i(clk_i), .rst_i(rst_i), .level_i(inc_i), .edge_o(inc_edge)
  );

`ifdef WATCH_SET_AUTOEXIT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_S - 1);

  logic [7:0] idle_q;
  logic       in_set;

  assign in_set  = (state_q == SET_H) || (state_q == SET_M);
  // A button edge in the expiring cycle restarts the idle window instead of exiting.
  assign timeout = in_set && tick_i && (idle_q == TIMEOUT_LAST) && !inc_edge && !mode_edge;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                       idle_q <= 8'd0;
    else if (!in_set || (state_d != state_q) || mode_edge || inc_edge) idle_q <= 8'd0;
    else if (tick_i)                                                 idle_q <= idle_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_edge) state_d = SET_H;
      SET_H:   if (mode_edge) state_d = SET_M;  else if (timeout) state_d = COMMIT;
      SET_M:   if (mode_edge) state_d = COMMIT; else if (timeout) state_d = COMMIT;
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Shadow edit path and blink phase; mode edges always pre-empt an increment.
  always_comb begin
    shadow_d = shadow_q;
    case (state_q)
      RUN:     if (mode_edge) shadow_d = bcd_time_valid(cur_time_i) ? cur_time_i : 16'h0000;
      SET_H:   if (inc_edge && !mode_edge) shadow_d[15:8] = bcd2_inc(shadow_q[15:8], HOUR_MAX_BCD);
      SET_M:   if (inc_edge && !mode_edge) shadow_d[7:0]  = bcd2_inc(shadow_q[7:0], MIN_MAX_BCD);
      default: ;
    endcase
    phase_d = (state_d != state_q) ? 1'b0 : (phase_q ^ tick_i);
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_comb begin
    cnt_rstn_d = (state_d == RUN);
    blank_d    = {(state_d == SET_H) & phase_d, (state_d == SET_M) & phase_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q   <= 16'h0000;
      phase_q    <= 1'b0;
      cnt_rstn_q <= 1'b0;
      blank_q    <= 2'b00;
    end else begin
      shadow_q   <= shadow_d;
      phase_q    <= phase_d;
      cnt_rstn_q <= cnt_rstn_d;
      blank_q    <= blank_d;
    end
  end

  assign ival_o     = shadow_q;
  assign cnt_rstn_o = cnt_rstn_q;
  assign blank_o    = blank_q;
  assign state_o    = state_q;

endmodule
